// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the two-requester multiplier arbiter.
package mul_arb_pkg;

    localparam int unsigned OPW         = 8;
    localparam int unsigned PW          = 16;
    localparam int unsigned CNTW        = 6;
    localparam int unsigned TIMEOUT_DEF = 63;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GO   = 2'd1,
        ST_BUSY = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef struct packed {
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
    } operand_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin select; pointer remembers the last served requester.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       update,
    input  logic       served_id,
    output logic [1:0] grant_c
);

    logic last_q;

    // Reset to "1 served last" so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= served_id;
        end
    end

    always_comb begin
        grant_c = 2'b00;
        if (req0 && req1) begin
            grant_c = last_q ? 2'b01 : 2'b10;
        end else if (req0) begin
            grant_c = 2'b01;
        end else if (req1) begin
            grant_c = 2'b10;
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Arbitrates two requesters onto one shared multiplier, one operation in flight,
// with a BUSY-state timeout that returns an error response.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0,
    input  logic            req1,
    input  logic [OPW-1:0]  a0,
    input  logic [OPW-1:0]  b0,
    input  logic [OPW-1:0]  a1,
    input  logic [OPW-1:0]  b1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            rsp_valid,
    output logic            rsp_id,
    output logic [PW-1:0]   rsp_p,
    output logic            rsp_err,
    output logic            mgo,
    output logic [OPW-1:0]  main,
    output logic [OPW-1:0]  mpin,
    input  logic            mdone,
    input  logic [PW-1:0]   mp
);

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            cur_id_q, cur_id_d;
    operand_t        op_q, op_d;
    logic [1:0]      gnt_d;
    logic            mgo_d, rsp_valid_d, rsp_id_d, rsp_err_d;
    logic [PW-1:0]   rsp_p_d;
    logic [1:0]      grant_c;
    logic            timeout_hit_c;

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .update    (state_q == ST_RESP),
        .served_id (cur_id_q),
        .grant_c   (grant_c)
    );

    assign timeout_hit_c = (cnt_q + CNTW'(1)) == CNTW'(TIMEOUT);
    assign main          = op_q.a;
    assign mpin          = op_q.b;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cur_id_q  <= 1'b0;
            op_q      <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            mgo       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_p     <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_id_q  <= cur_id_d;
            op_q      <= op_d;
            gnt0      <= gnt_d[0];
            gnt1      <= gnt_d[1];
            mgo       <= mgo_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_p     <= rsp_p_d;
            rsp_err   <= rsp_err_d;
        end
    end

    // Next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req0 || req1)            state_d = ST_GO;
            ST_GO:                                state_d = ST_BUSY;
            ST_BUSY: if (mdone || timeout_hit_c)  state_d = ST_RESP;
            ST_RESP:                              state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; pulses default low, held values default to hold
    always_comb begin
        gnt_d       = 2'b00;
        mgo_d       = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id;
        rsp_p_d     = rsp_p;
        rsp_err_d   = rsp_err;
        cnt_d       = cnt_q;
        cur_id_d    = cur_id_q;
        op_d        = op_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_c != 2'b00) begin
                    gnt_d    = grant_c;
                    cur_id_d = grant_c[1];
                    op_d     = grant_c[1] ? operand_t'({a1, b1}) : operand_t'({a0, b0});
                end
            end
            ST_GO: begin
                mgo_d = 1'b1;
                cnt_d = '0;
            end
            ST_BUSY: begin
                if (mdone) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = cur_id_q;
                    rsp_p_d     = mp;
                    rsp_err_d   = 1'b0;
                end else if (timeout_hit_c) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = cur_id_q;
                    rsp_p_d     = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: stimulus pushes expected grants/responses,
// a monitor pops and compares whenever the DUT presents gnt/mgo/rsp_valid.
module tb_mul_arbiter;

    typedef struct packed { logic [7:0] a; logic [7:0] b; } op_t;
    typedef struct packed { logic id; logic [7:0] a; logic [7:0] b; } gexp_t;
    typedef struct packed { logic id; logic [15:0] p; logic err; } rexp_t;

    logic        clk, reset;
    logic        req0, req1;
    logic [7:0]  a0, b0, a1, b1;
    logic        gnt0, gnt1, rsp_valid, rsp_id, rsp_err, mgo, mdone;
    logic [15:0] rsp_p, mp;
    logic [7:0]  main, mpin;

    op_t   opq0[$], opq1[$];
    gexp_t exp_gnt[$];
    rexp_t exp_rsp[$];

    int    checks, errors;
    int    cyc, mgo_cyc, mul_lat;
    bit    auto_mul, prev_gnt, prev_mdone;
    logic [7:0] cur_a, cur_b;

    mul_arbiter #(.TIMEOUT(10)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p), .rsp_err(rsp_err),
        .mgo(mgo), .main(main), .mpin(mpin),
        .mdone(mdone), .mp(mp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt0"}, gnt0, 0);
        chk({tag, "_gnt1"}, gnt1, 0);
        chk({tag, "_mgo"}, mgo, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_rsp_p"}, rsp_p, 0);
        chk({tag, "_main"}, main, 0);
        chk({tag, "_mpin"}, mpin, 0);
    endtask

    // Holds each requester's req high with the head operand until its gnt is seen
    task automatic requester();
        forever begin
            @(negedge clk);
            if (gnt0 && opq0.size() > 0) void'(opq0.pop_front());
            if (gnt1 && opq1.size() > 0) void'(opq1.pop_front());
            req0 = (opq0.size() != 0);
            req1 = (opq1.size() != 0);
            if (req0) {a0, b0} = opq0[0];
            if (req1) {a1, b1} = opq1[0];
        end
    endtask

    // Multiplier model: mdone pulse mul_lat cycles after the mgo cycle
    task automatic responder();
        logic [7:0] pa, pb;
        forever begin
            @(negedge clk);
            if (mgo && auto_mul) begin
                pa = main;
                pb = mpin;
                repeat (mul_lat) begin @(posedge clk); #1; end
                mdone = 1'b1;
                mp    = 16'(pa) * 16'(pb);
                @(posedge clk); #1;
                mdone = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        gexp_t g;
        rexp_t r;
        forever begin
            @(negedge clk);
            cyc++;
            if (gnt0 || gnt1) begin
                chk("gnt_onehot", 32'(gnt0 & gnt1), 0);
                if (exp_gnt.size() == 0) begin
                    chk("unexpected_gnt", 1, 0);
                end else begin
                    g = exp_gnt.pop_front();
                    chk("gnt_id", 32'(gnt1), 32'(g.id));
                    cur_a = g.a;
                    cur_b = g.b;
                end
            end
            if (mgo) begin
                chk("gnt_to_mgo", 32'(prev_gnt), 1);
                chk("main", main, cur_a);
                chk("mpin", mpin, cur_b);
                mgo_cyc = cyc;
            end
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(r.id));
                    chk("rsp_p", rsp_p, r.p);
                    chk("rsp_err", 32'(rsp_err), 32'(r.err));
                    if (r.err) chk("timeout_lat", 32'(cyc - mgo_cyc), 10);
                    else       chk("mdone_to_rsp", 32'(prev_mdone), 1);
                end
            end
            if (gnt0 || gnt1 || mgo || rsp_valid)
                chk("one_pulse", 32'(gnt0) + 32'(gnt1) + 32'(mgo) + 32'(rsp_valid), 1);
            prev_gnt   = gnt0 | gnt1;
            prev_mdone = mdone;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            done = exp_gnt.size() == 0 && exp_rsp.size() == 0 &&
                   opq0.size() == 0 && opq1.size() == 0;
        end
        chk({"drain_", name}, 32'(done), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_sig(input string name, input bit use_mgo);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = use_mgo ? mgo : gnt1;
        end
        chk({"wait_", name}, 32'(seen), 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        mdone = 1'b0; mp = '0;
        checks = 0; errors = 0; cyc = 0; mgo_cyc = 0;
        auto_mul = 1'b1; mul_lat = 8;
        prev_gnt = 1'b0; prev_mdone = 1'b0; cur_a = '0; cur_b = '0;
        fork
            requester();
            responder();
            monitor();
        join_none

        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst");

        // Single requester 0: 3*5
        exp_gnt.push_back('{1'b0, 8'd3, 8'd5});
        exp_rsp.push_back('{1'b0, 16'd15, 1'b0});
        opq0.push_back('{8'd3, 8'd5});
        wait_drain("single0", 60);

        // Tie right after reset: 0 first, then 1
        do_reset();
        exp_gnt.push_back('{1'b0, 8'd2, 8'd7});
        exp_gnt.push_back('{1'b1, 8'd255, 8'd255});
        exp_rsp.push_back('{1'b0, 16'd14, 1'b0});
        exp_rsp.push_back('{1'b1, 16'd65025, 1'b0});
        opq0.push_back('{8'd2, 8'd7});
        opq1.push_back('{8'd255, 8'd255});
        wait_drain("tie", 100);

        // Both held for four operations: alternate 0,1,0,1
        exp_gnt.push_back('{1'b0, 8'd1, 8'd1});
        exp_gnt.push_back('{1'b1, 8'd16, 8'd16});
        exp_gnt.push_back('{1'b0, 8'd4, 8'd4});
        exp_gnt.push_back('{1'b1, 8'd200, 8'd3});
        exp_rsp.push_back('{1'b0, 16'd1, 1'b0});
        exp_rsp.push_back('{1'b1, 16'd256, 1'b0});
        exp_rsp.push_back('{1'b0, 16'd16, 1'b0});
        exp_rsp.push_back('{1'b1, 16'd600, 1'b0});
        opq0.push_back('{8'd1, 8'd1});
        opq0.push_back('{8'd4, 8'd4});
        opq1.push_back('{8'd16, 8'd16});
        opq1.push_back('{8'd200, 8'd3});
        wait_drain("rr4", 200);

        // Timeout on requester 1, then a tie goes to 0
        auto_mul = 1'b0;
        exp_gnt.push_back('{1'b1, 8'd9, 8'd9});
        exp_rsp.push_back('{1'b1, 16'd0, 1'b1});
        opq1.push_back('{8'd9, 8'd9});
        wait_drain("timeout", 60);
        auto_mul = 1'b1;
        exp_gnt.push_back('{1'b0, 8'd5, 8'd6});
        exp_gnt.push_back('{1'b1, 8'd7, 8'd8});
        exp_rsp.push_back('{1'b0, 16'd30, 1'b0});
        exp_rsp.push_back('{1'b1, 16'd56, 1'b0});
        opq0.push_back('{8'd5, 8'd6});
        opq1.push_back('{8'd7, 8'd8});
        wait_drain("after_timeout", 100);

        // Reset during BUSY; the late mdone must produce nothing
        exp_gnt.push_back('{1'b0, 8'd10, 8'd10});
        opq0.push_back('{8'd10, 8'd10});
        wait_sig("mgo_before_reset", 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        repeat (12) @(negedge clk);
        chk_reset_vals("postmdone");
        exp_gnt.push_back('{1'b0, 8'd12, 8'd12});
        exp_rsp.push_back('{1'b0, 16'd144, 1'b0});
        opq0.push_back('{8'd12, 8'd12});
        wait_drain("after_reset", 60);

        // mdone in IDLE and in the GO cycle is ignored
        auto_mul = 1'b0;
        @(posedge clk); #1;
        mdone = 1'b1; mp = 16'hdead;
        @(posedge clk); #1;
        mdone = 1'b0;
        repeat (3) @(negedge clk);
        exp_gnt.push_back('{1'b1, 8'd3, 8'd4});
        exp_rsp.push_back('{1'b1, 16'd12, 1'b0});
        opq1.push_back('{8'd3, 8'd4});
        wait_sig("gnt1_go", 1'b0);
        mdone = 1'b1; mp = 16'd999;
        @(posedge clk); #1;
        mdone = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        mdone = 1'b1; mp = 16'd12;
        @(posedge clk); #1;
        mdone = 1'b0;
        wait_drain("mdone_ignore", 40);
        chk("rsp_p_hold", rsp_p, 12);
        chk("rsp_id_hold", 32'(rsp_id), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
